audiosystem_fifo_ctrl: RTL and testbench

Parametrised single-clock sample FIFO between the audio DMA/CPU writer and the codec-side reader. It exposes two Avalon-MM data slaves (write, read) and adds a 4-word CSR slave.
- CSR provides fill level, almost-full/almost-empty thresholds, sticky overflow/underflow flags, flush, and an interrupt.
- Supports blocking (waitrequest) and drop (non-blocking) modes.
- Storage is an inferred register/RAM array, not a vendor macro.

---
 rtl/audiosystem_fifo_pkg.sv | 25 ++
 rtl/audiosystem_fifo_mem.sv | 26 ++
 rtl/audiosystem_fifo_ctrl.sv | 162 ++++++++++++++++
 tb/tb_audiosystem_fifo_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audiosystem_fifo_pkg.sv
// Shared constants for the audio sample FIFO controller: CSR word map,
// status/control bit positions and flow-control modes.
package audiosystem_fifo_pkg;

   typedef enum logic [1:0] {
      CSR_LEVEL = 2'd0,
      CSR_AF    = 2'd1,
      CSR_AE    = 2'd2,
      CSR_STAT  = 2'd3
   } csr_addr_e;

   localparam int STAT_EMPTY      = 0;
   localparam int STAT_FULL       = 1;
   localparam int STAT_AF         = 2;
   localparam int STAT_AE         = 3;
   localparam int STAT_OVF        = 4;
   localparam int STAT_UNF        = 5;
   localparam int CTRL_IRQ_EN_AE  = 8;
   localparam int CTRL_IRQ_EN_ERR = 9;
   localparam int CTRL_FLUSH      = 31;

   localparam int MODE_BLOCKING = 0;
   localparam int MODE_DROP     = 1;

endpackage

// File: rtl/audiosystem_fifo_mem.sv
// Sample storage array: synchronous write port, asynchronous read port so the
// head word is visible in the same cycle (show-ahead).
module audiosystem_fifo_mem #(
   parameter int DATA_W     = 32,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] waddr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DEPTH_LOG2-1:0] raddr,
   output logic [DATA_W-1:0]     rdata
);

   logic [DATA_W-1:0] mem_r [1 << DEPTH_LOG2];

   // Write port; contents are intentionally not reset
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/audiosystem_fifo_ctrl.sv
// Single-clock sample FIFO with Avalon-MM write/read data slaves, a 4-word
// CSR slave (level, thresholds, sticky errors, flush) and a level interrupt.
module audiosystem_fifo_ctrl
   import audiosystem_fifo_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int DEPTH_LOG2 = 4,
   parameter int DROP_MODE  = MODE_BLOCKING,
   parameter int AF_RESET   = (1 << DEPTH_LOG2) - 2,
   parameter int AE_RESET   = 2
) (
   input  logic              wrclock,
   input  logic              reset_n,
   input  logic              avalonmm_write_slave_write,
   input  logic [DATA_W-1:0] avalonmm_write_slave_writedata,
   output logic              avalonmm_write_slave_waitrequest,
   input  logic              avalonmm_read_slave_read,
   output logic [DATA_W-1:0] avalonmm_read_slave_readdata,
   output logic              avalonmm_read_slave_waitrequest,
   input  logic [1:0]        csr_address,
   input  logic              csr_read,
   input  logic              csr_write,
   input  logic [31:0]       csr_writedata,
   output logic [31:0]       csr_readdata,
   output logic              irq
);

   localparam int LVL_W = DEPTH_LOG2 + 1;
   localparam logic [LVL_W-1:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam bit DROP = (DROP_MODE == MODE_DROP);

   logic [DEPTH_LOG2-1:0] wr_ptr_r;
   logic [DEPTH_LOG2-1:0] rd_ptr_r;
   logic [LVL_W-1:0]      level_r;
   logic [LVL_W-1:0]      af_thresh_r;
   logic [LVL_W-1:0]      ae_thresh_r;
   logic                  overflow_r;
   logic                  underflow_r;
   logic                  irq_en_ae_r;
   logic                  irq_en_err_r;
   logic                  irq_r;

   logic [DATA_W-1:0]     mem_rdata_s;
   logic                  empty_s;
   logic                  full_s;
   logic                  almost_full_s;
   logic                  almost_empty_s;
   logic                  stat_wr_s;
   logic                  flush_s;
   logic                  wr_acc_s;
   logic                  rd_acc_s;
   logic                  ovf_set_s;
   logic                  unf_set_s;
   logic                  unused_s;

   assign empty_s        = (level_r == {LVL_W{1'b0}});
   assign full_s         = (level_r == FULL_LVL);
   assign almost_full_s  = (level_r >= af_thresh_r);
   assign almost_empty_s = (level_r <= ae_thresh_r);

   assign stat_wr_s = csr_write && (csr_address == CSR_STAT);
   assign flush_s   = stat_wr_s && csr_writedata[CTRL_FLUSH];

   // Full/empty decisions use the pre-edge level, so a simultaneous read never frees room for the write
   assign wr_acc_s  = reset_n && avalonmm_write_slave_write && !full_s && !flush_s;
   assign rd_acc_s  = avalonmm_read_slave_read && !empty_s;
   assign ovf_set_s = DROP && avalonmm_write_slave_write && full_s;
   assign unf_set_s = DROP && avalonmm_read_slave_read && empty_s;

   assign avalonmm_write_slave_waitrequest = !reset_n || (!DROP && full_s);
   assign avalonmm_read_slave_waitrequest  = !DROP && empty_s;
   assign avalonmm_read_slave_readdata     = (DROP && empty_s) ? {DATA_W{1'b0}} : mem_rdata_s;
   assign irq      = irq_r;
   assign unused_s = ^csr_writedata;

   audiosystem_fifo_mem #(
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_mem (
      .clk   (wrclock),
      .we    (wr_acc_s),
      .waddr (wr_ptr_r),
      .wdata (avalonmm_write_slave_writedata),
      .raddr (rd_ptr_r),
      .rdata (mem_rdata_s)
   );

   // Pointers, level, CSR registers and interrupt
   always_ff @(posedge wrclock) begin
      if (!reset_n) begin
         wr_ptr_r     <= {DEPTH_LOG2{1'b0}};
         rd_ptr_r     <= {DEPTH_LOG2{1'b0}};
         level_r      <= {LVL_W{1'b0}};
         af_thresh_r  <= LVL_W'(AF_RESET);
         ae_thresh_r  <= LVL_W'(AE_RESET);
         overflow_r   <= 1'b0;
         underflow_r  <= 1'b0;
         irq_en_ae_r  <= 1'b0;
         irq_en_err_r <= 1'b0;
         irq_r        <= 1'b0;
      end else begin
         if (flush_s) begin
            wr_ptr_r <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r <= {DEPTH_LOG2{1'b0}};
            level_r  <= {LVL_W{1'b0}};
         end else begin
            if (wr_acc_s) begin
               wr_ptr_r <= wr_ptr_r + DEPTH_LOG2'(1);
            end
            if (rd_acc_s) begin
               rd_ptr_r <= rd_ptr_r + DEPTH_LOG2'(1);
            end
            case ({wr_acc_s, rd_acc_s})
               2'b10:   level_r <= level_r + LVL_W'(1);
               2'b01:   level_r <= level_r - LVL_W'(1);
               default: level_r <= level_r;
            endcase
         end
         if (csr_write && (csr_address == CSR_AF)) begin
            af_thresh_r <= csr_writedata[LVL_W-1:0];
         end
         if (csr_write && (csr_address == CSR_AE)) begin
            ae_thresh_r <= csr_writedata[LVL_W-1:0];
         end
         if (stat_wr_s) begin
            irq_en_ae_r  <= csr_writedata[CTRL_IRQ_EN_AE];
            irq_en_err_r <= csr_writedata[CTRL_IRQ_EN_ERR];
         end
         // A new error event outranks a same-cycle write-1-to-clear
         overflow_r  <= ovf_set_s || (overflow_r && !(stat_wr_s && csr_writedata[STAT_OVF]));
         underflow_r <= unf_set_s || (underflow_r && !(stat_wr_s && csr_writedata[STAT_UNF]));
         irq_r       <= (irq_en_ae_r && almost_empty_s) ||
                        (irq_en_err_r && (overflow_r || underflow_r));
      end
   end

   // CSR read mux, zero wait state
   always_comb begin
      csr_readdata = 32'h0000_0000;
      if (csr_read) begin
         case (csr_address)
            CSR_LEVEL: csr_readdata = 32'(level_r);
            CSR_AF:    csr_readdata = 32'(af_thresh_r);
            CSR_AE:    csr_readdata = 32'(ae_thresh_r);
            CSR_STAT: begin
               csr_readdata[STAT_EMPTY]      = empty_s;
               csr_readdata[STAT_FULL]       = full_s;
               csr_readdata[STAT_AF]         = almost_full_s;
               csr_readdata[STAT_AE]         = almost_empty_s;
               csr_readdata[STAT_OVF]        = overflow_r;
               csr_readdata[STAT_UNF]        = underflow_r;
               csr_readdata[CTRL_IRQ_EN_AE]  = irq_en_ae_r;
               csr_readdata[CTRL_IRQ_EN_ERR] = irq_en_err_r;
            end
            default:   csr_readdata = 32'h0000_0000;
         endcase
      end else begin
         csr_readdata = 32'h0000_0000;
      end
   end

endmodule

// File: tb/tb_audiosystem_fifo_ctrl.sv
// Self-checking bench: a blocking and a drop-mode FIFO share stimulus; the
// active one is compared every cycle against a queue-based reference model.
module tb_audiosystem_fifo_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        write = 1'b0;
   logic [31:0] wdata = 32'h0;
   logic        read = 1'b0;
   logic [1:0]  csr_addr = 2'd0;
   logic        csr_rd = 1'b0;
   logic        csr_wr = 1'b0;
   logic [31:0] csr_wd = 32'h0;

   logic        b_wwait, b_rwait, b_irq, d_wwait, d_rwait, d_irq;
   logic [31:0] b_rdata, b_csr, d_rdata, d_csr;

   always #5 clk = ~clk;

   audiosystem_fifo_ctrl #(.DATA_W(32), .DEPTH_LOG2(4), .DROP_MODE(0)) dut_blk (
      .wrclock(clk), .reset_n(rst_n),
      .avalonmm_write_slave_write(write), .avalonmm_write_slave_writedata(wdata),
      .avalonmm_write_slave_waitrequest(b_wwait),
      .avalonmm_read_slave_read(read), .avalonmm_read_slave_readdata(b_rdata),
      .avalonmm_read_slave_waitrequest(b_rwait),
      .csr_address(csr_addr), .csr_read(csr_rd), .csr_write(csr_wr),
      .csr_writedata(csr_wd), .csr_readdata(b_csr), .irq(b_irq));

   audiosystem_fifo_ctrl #(.DATA_W(32), .DEPTH_LOG2(4), .DROP_MODE(1)) dut_drop (
      .wrclock(clk), .reset_n(rst_n),
      .avalonmm_write_slave_write(write), .avalonmm_write_slave_writedata(wdata),
      .avalonmm_write_slave_waitrequest(d_wwait),
      .avalonmm_read_slave_read(read), .avalonmm_read_slave_readdata(d_rdata),
      .avalonmm_read_slave_waitrequest(d_rwait),
      .csr_address(csr_addr), .csr_read(csr_rd), .csr_write(csr_wr),
      .csr_writedata(csr_wd), .csr_readdata(d_csr), .irq(d_irq));

   int errors = 0;
   int checks = 0;
   int mode = 0;

   // Reference model state
   logic [31:0] q[$];
   int          af = 14, ae = 2;
   bit          ovf, unf, en_ae, en_err, irq_m;

   // Snapshot of the selected DUT's outputs, taken before the edge
   logic        s_wwait, s_rwait, s_irq;
   logic [31:0] s_rdata, s_csr;

   typedef struct {
      logic [1:0]  addr;
      logic [31:0] wd;
      logic [31:0] exp;
   } csr_vec_t;
   csr_vec_t tbl[8];

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t mode=%0d)", name, act, exp, $time, mode);
      end
   endtask

   function automatic logic [31:0] exp_csr(logic [1:0] a);
      int lvl;
      logic [31:0] r;
      lvl = q.size();
      case (a)
         2'd0:    r = 32'(lvl);
         2'd1:    r = 32'(af);
         2'd2:    r = 32'(ae);
         default: r = {22'b0, en_err, en_ae, 2'b0, unf, ovf, (lvl <= ae), (lvl >= af),
                       (lvl == 16), (lvl == 0)};
      endcase
      return r;
   endfunction

   task automatic model_update();
      int lvl;
      bit full, empty, stw, flush, irq_n;
      lvl   = q.size();
      full  = (lvl == 16);
      empty = (lvl == 0);
      stw   = csr_wr && (csr_addr == 2'd3);
      flush = stw && csr_wd[31];
      irq_n = (en_ae && (lvl <= ae)) || (en_err && (ovf || unf));
      if (!rst_n) begin
         q.delete();
         af = 14; ae = 2;
         ovf = 1'b0; unf = 1'b0; en_ae = 1'b0; en_err = 1'b0; irq_m = 1'b0;
      end else begin
         if (read && !empty) void'(q.pop_front());
         if (write && !full && !flush) q.push_back(wdata);
         if (flush) q.delete();
         ovf = ((mode == 1) && write && full) || (ovf && !(stw && csr_wd[4]));
         unf = ((mode == 1) && read && empty) || (unf && !(stw && csr_wd[5]));
         if (csr_wr && csr_addr == 2'd1) af = int'(csr_wd & 32'd31);
         if (csr_wr && csr_addr == 2'd2) ae = int'(csr_wd & 32'd31);
         if (stw) begin
            en_ae  = csr_wd[8];
            en_err = csr_wd[9];
         end
         irq_m = irq_n;
      end
   endtask

   task automatic tick();
      int lvl;
      @(negedge clk);
      s_wwait = (mode == 1) ? d_wwait : b_wwait;
      s_rwait = (mode == 1) ? d_rwait : b_rwait;
      s_rdata = (mode == 1) ? d_rdata : b_rdata;
      s_csr   = (mode == 1) ? d_csr : b_csr;
      s_irq   = (mode == 1) ? d_irq : b_irq;
      lvl = q.size();
      check("wr_waitrequest", 32'(s_wwait), 32'(!rst_n || (mode == 0 && lvl == 16)));
      check("rd_waitrequest", 32'(s_rwait), 32'(mode == 0 && lvl == 0));
      if (lvl != 0) check("readdata", s_rdata, q[0]);
      else if (mode == 1) check("readdata_empty", s_rdata, 32'h0);
      check("irq", 32'(s_irq), 32'(irq_m));
      if (csr_rd) check("csr_readdata", s_csr, exp_csr(csr_addr));
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle();
      write = 1'b0; read = 1'b0; csr_rd = 1'b0; csr_wr = 1'b0; csr_wd = 32'h0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      tick();
      check("reset_wr_wait", 32'(s_wwait), 32'd1);
      tick();
      rst_n = 1'b1;
   endtask

   task automatic switch_mode(int m);
      idle();
      mode  = m;
      rst_n = 1'b0;
      repeat (2) begin
         @(posedge clk);
         model_update();
         #1;
      end
      rst_n = 1'b1;
   endtask

   task automatic push(logic [31:0] d);
      write = 1'b1; wdata = d;
      tick();
      write = 1'b0;
   endtask

   task automatic csr_put(logic [1:0] a, logic [31:0] d);
      csr_addr = a; csr_wr = 1'b1; csr_wd = d;
      tick();
      csr_wr = 1'b0; csr_wd = 32'h0;
   endtask

   task automatic csr_get(logic [1:0] a, output logic [31:0] v);
      csr_addr = a; csr_rd = 1'b1;
      tick();
      v = s_csr;
      csr_rd = 1'b0;
   endtask

   task automatic random_phase(int n);
      bit wbias;
      for (int c = 0; c < n; c++) begin
         wbias    = ((c / 64) % 2) == 0;
         write    = wbias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         read     = wbias ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         wdata    = $urandom;
         csr_addr = 2'($urandom_range(0, 3));
         csr_rd   = ($urandom_range(0, 1) == 1);
         csr_wr   = ($urandom_range(0, 9) == 0);
         csr_wd   = $urandom & 32'h7FFF_FFFF;
         if ($urandom_range(0, 15) == 0) csr_wd[31] = 1'b1;
         rst_n    = ($urandom_range(0, 299) != 0);
         tick();
      end
      idle();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] v;
      int wcnt, rcnt, sel;

      tbl[0] = '{2'd1, 32'h0000_000A, 32'h0000_000A};
      tbl[1] = '{2'd1, 32'hFFFF_FFE3, 32'h0000_0003};
      tbl[2] = '{2'd2, 32'h0000_0007, 32'h0000_0007};
      tbl[3] = '{2'd0, 32'h0000_0005, 32'h0000_0000};
      tbl[4] = '{2'd3, 32'h0000_0300, 32'h0000_0309};
      tbl[5] = '{2'd3, 32'h0000_0030, 32'h0000_0009};
      tbl[6] = '{2'd1, 32'h0000_000E, 32'h0000_000E};
      tbl[7] = '{2'd2, 32'h0000_0002, 32'h0000_0002};

      switch_mode(0);

      // Fill to full, stall on the 17th write, drain in order
      do_reset();
      csr_get(2'd0, v); check("reset_level", v, 32'h0);
      csr_get(2'd3, v); check("reset_status", v, 32'h9);
      for (int i = 1; i <= 16; i++) push(32'(i));
      write = 1'b1; wdata = 32'h11;
      tick();
      check("wr_wait_17th", 32'(s_wwait), 32'd1);
      write = 1'b0;
      csr_get(2'd0, v); check("full_level", v, 32'd16);
      csr_get(2'd3, v); check("full_status", v, 32'h6);
      for (int i = 1; i <= 16; i++) begin
         read = 1'b1;
         tick();
         check("read_order", s_rdata, 32'(i));
      end
      read = 1'b0;
      csr_get(2'd3, v); check("drained_status", v, 32'h9);

      // Simultaneous read and write when full
      for (int i = 0; i < 16; i++) push(32'h100 + 32'(i));
      read = 1'b1; write = 1'b1; wdata = 32'hAAAA_5555;
      tick();
      check("rw_full_wwait", 32'(s_wwait), 32'd1);
      check("rw_full_head", s_rdata, 32'h100);
      read = 1'b0; csr_addr = 2'd0; csr_rd = 1'b1;
      tick();
      check("rw_full_level15", s_csr, 32'd15);
      check("rw_retry_wwait", 32'(s_wwait), 32'd0);
      write = 1'b0; csr_rd = 1'b0;
      csr_get(2'd0, v); check("rw_level16", v, 32'd16);
      for (int i = 0; i < 16; i++) begin
         read = 1'b1;
         tick();
      end
      read = 1'b0;
      check("rw_last_word", s_rdata, 32'hAAAA_5555);

      // CSR register table
      foreach (tbl[i]) begin
         csr_put(tbl[i].addr, tbl[i].wd);
         csr_get(tbl[i].addr, v);
         check("csr_table", v, tbl[i].exp);
      end

      // Almost-empty interrupt and almost-full threshold
      do_reset();
      csr_put(2'd2, 32'd3);
      for (int i = 0; i < 4; i++) push(32'h300 + 32'(i));
      csr_put(2'd3, 32'h100);
      read = 1'b1; tick(); read = 1'b0;
      tick(); check("irq_before", 32'(s_irq), 32'd0);
      tick(); check("irq_after", 32'(s_irq), 32'd1);
      csr_put(2'd1, 32'd4);
      csr_get(2'd3, v); check("af_status_lvl3", v, 32'h108);
      push(32'h3FF);
      csr_get(2'd3, v); check("af_status_lvl4", v, 32'h104);

      // Flush with a concurrent write, then reset mid-burst
      do_reset();
      for (int i = 0; i < 9; i++) push(32'h400 + 32'(i));
      csr_get(2'd0, v); check("flush_pre_level", v, 32'd9);
      csr_addr = 2'd3; csr_wr = 1'b1; csr_wd = 32'h8000_0000;
      write = 1'b1; wdata = 32'h55;
      tick();
      idle();
      csr_get(2'd0, v); check("flush_level", v, 32'd0);
      csr_get(2'd3, v); check("flush_status", v, 32'h9);
      push(32'h77);
      read = 1'b1; tick(); read = 1'b0;
      check("flush_new_word", s_rdata, 32'h77);
      for (int i = 0; i < 3; i++) push(32'h500 + 32'(i));
      write = 1'b1; rst_n = 1'b0;
      tick();
      check("midburst_reset_wwait", 32'(s_wwait), 32'd1);
      write = 1'b0; rst_n = 1'b1;
      csr_get(2'd0, v); check("midburst_reset_level", v, 32'd0);

      // Pointer wrap with level kept between 1 and 3
      do_reset();
      wcnt = 0; rcnt = 0;
      push(32'h500); wcnt++;
      for (int k = 0; k < 40; k++) begin
         sel = $urandom_range(0, 2);
         write = !(sel == 1 && q.size() > 1);
         read  = !(sel == 0 && q.size() < 3);
         wdata = 32'h500 + 32'(wcnt);
         tick();
         if (write) wcnt++;
         if (read) begin
            check("wrap_order", s_rdata, 32'h500 + 32'(rcnt));
            rcnt++;
         end
      end
      idle();

      random_phase(600);

      // Drop mode: overflow, underflow, write-1-to-clear
      switch_mode(1);
      for (int i = 0; i < 16; i++) push(32'h200 + 32'(i));
      push(32'hDEAD_BEEF);
      check("drop_no_stall", 32'(s_wwait), 32'd0);
      csr_get(2'd3, v); check("drop_ovf_status", v, 32'h16);
      for (int i = 0; i < 16; i++) begin
         read = 1'b1;
         tick();
         check("drop_kept_data", s_rdata, 32'h200 + 32'(i));
      end
      tick();
      check("drop_empty_rdata", s_rdata, 32'h0);
      read = 1'b0;
      csr_get(2'd3, v); check("drop_unf_status", v, 32'h39);
      csr_put(2'd3, 32'h30);
      csr_get(2'd3, v); check("drop_w1c_status", v, 32'h9);

      random_phase(600);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
